mem_stage: RTL and testbench

- Memory-access stage, directly downstream of the EX/MEM pipeline register; consumes its outputs and feeds the WB stage.
- Drives a request/response data bus for loads and stores.
- Aligns store data and byte strobes; sign/zero-extends load data; selects the register-file write-back value.
- Registers the result into MEM/WB outputs and raises mem_stall, which drives the suspend input of the upstream pipeline registers.

---
 rtl/mem_stage_pkg.sv | 66 ++++++
 rtl/mem_load_ext.sv | 33 +++
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_stage_pkg : shared encodings and helpers for the memory-access stage   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_stage_pkg;

  // Write-back source select
  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_LOAD = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;
  localparam logic [1:0] WD_EXT  = 2'd3;

  // Load extension ops
  localparam logic [2:0] EXT_WORD   = 3'd0;
  localparam logic [2:0] EXT_BYTE_S = 3'd1;
  localparam logic [2:0] EXT_BYTE_U = 3'd2;
  localparam logic [2:0] EXT_HALF_S = 3'd3;
  localparam logic [2:0] EXT_HALF_U = 3'd4;

  // Store size masks, aligned to lane 0
  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_BYTE = 4'b0001;
  localparam logic [3:0] WE_HALF = 4'b0011;
  localparam logic [3:0] WE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // Stores are sized by their strobe mask, loads by their extension op
  function automatic acc_size_t access_size(input logic       is_store,
                                            input logic [3:0] we,
                                            input logic [2:0] ext_op);
    acc_size_t sz;
    sz = SZ_WORD;
    if (is_store) begin
      if (we == WE_BYTE)      sz = SZ_BYTE;
      else if (we == WE_HALF) sz = SZ_HALF;
    end else begin
      if (ext_op == EXT_BYTE_S || ext_op == EXT_BYTE_U)      sz = SZ_BYTE;
      else if (ext_op == EXT_HALF_S || ext_op == EXT_HALF_U) sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] lo);
    logic m;
    m = 1'b0;
    if (sz == SZ_HALF)      m = lo[0];
    else if (sz == SZ_WORD) m = (lo != 2'b00);
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_ext.sv
// +----------------------------------------------------------------------------+
// | mem_load_ext : byte/half lane select with sign or zero extension           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ext_op,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ext_op)
      EXT_BYTE_S: data = {{24{lane_b[7]}}, lane_b};
      EXT_BYTE_U: data = {24'd0, lane_b};
      EXT_HALF_S: data = {{16{lane_h[15]}}, lane_h};
      EXT_HALF_U: data = {16'd0, lane_h};
      default:    data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// +----------------------------------------------------------------------------+
// | mem_stage : memory-access pipeline stage with req/resp data bus and MEM/WB |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              valid_in,
  input  logic [4:0]        wR_in,
  input  logic [31:0]       pc4_in,
  input  logic [31:0]       alu_C_in,
  input  logic [DATA_W-1:0] rD2_in,
  input  logic [31:0]       ext_in,
  input  logic              rf_we_in,
  input  logic [1:0]        wd_sel_in,
  input  logic [3:0]        ram_we_in,
  input  logic [2:0]        ram_ext_op_in,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              mem_stall,
  output logic              valid_out,
  output logic [4:0]        wR_out,
  output logic [DATA_W-1:0] wd_out,
  output logic              rf_we_out,
  output logic              ale_out
);

  mem_state_t  state, state_nx;
  acc_size_t   size;
  logic        is_store, is_load, mem_op, misaligned, aligned_op, done;
  logic [1:0]  k;
  logic [31:0] load_data;
  logic [31:0] wd_next;

  always_comb begin
    k          = alu_C_in[1:0];
    is_store   = (ram_we_in != WE_NONE);
    is_load    = (wd_sel_in == WD_LOAD);
    mem_op     = valid_in && (is_store || is_load);
    size       = access_size(is_store, ram_we_in, ram_ext_op_in);
    misaligned = mem_op && is_misaligned(size, k);
    aligned_op = mem_op && !misaligned;
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Data arriving outside WAIT is ignored; the slave never pairs it with addr_ok
  always_comb begin
    state_nx = state;
    data_req = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (aligned_op) begin
          data_req = 1'b1;
          state_nx = data_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        data_req = 1'b1;
        if (data_addr_ok) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign mem_stall = aligned_op && !done;

  always_comb begin
    data_wr    = is_store;
    data_addr  = {alu_C_in[ADDR_W-1:2], 2'b00};
    data_wstrb = ram_we_in << k;
    case (ram_we_in)
      WE_BYTE: data_wdata = {4{rD2_in[7:0]}};
      WE_HALF: data_wdata = {2{rD2_in[15:0]}};
      default: data_wdata = rD2_in;
    endcase
  end

  mem_load_ext u_load_ext (
    .rdata   (data_rdata),
    .addr_lo (k),
    .ext_op  (ram_ext_op_in),
    .data    (load_data)
  );

  always_comb begin
    case (wd_sel_in)
      WD_LOAD: wd_next = load_data;
      WD_PC4:  wd_next = pc4_in;
      WD_EXT:  wd_next = ext_in;
      default: wd_next = alu_C_in;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      valid_out <= 1'b0;
      rf_we_out <= 1'b0;
      ale_out   <= 1'b0;
      wR_out    <= 5'd0;
      wd_out    <= '0;
    end else begin
      valid_out <= valid_in && !mem_stall;
      rf_we_out <= rf_we_in && valid_in && !mem_stall && !misaligned;
      ale_out   <= misaligned;
      if (valid_in && !mem_stall) begin
        wR_out <= wR_in;
        wd_out <= wd_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// +----------------------------------------------------------------------------+
// | tb_mem_stage : directed vector table plus handshake/reset sequences        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage;

  logic        cpu_clk, cpu_rst;
  logic        valid_in, rf_we_in;
  logic [4:0]  wR_in;
  logic [31:0] pc4_in, alu_C_in, rD2_in, ext_in;
  logic [1:0]  wd_sel_in;
  logic [3:0]  ram_we_in;
  logic [2:0]  ram_ext_op_in;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        mem_stall, valid_out, rf_we_out, ale_out;
  logic [4:0]  wR_out;
  logic [31:0] wd_out;

  mem_stage dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .valid_in(valid_in), .wR_in(wR_in),
    .pc4_in(pc4_in), .alu_C_in(alu_C_in), .rD2_in(rD2_in), .ext_in(ext_in),
    .rf_we_in(rf_we_in), .wd_sel_in(wd_sel_in), .ram_we_in(ram_we_in),
    .ram_ext_op_in(ram_ext_op_in), .data_req(data_req), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_stall(mem_stall), .valid_out(valid_out), .wR_out(wR_out), .wd_out(wd_out),
    .rf_we_out(rf_we_out), .ale_out(ale_out)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef logic [31:0] u32;
  typedef struct {
    u32 valid; u32 wd_sel; u32 ram_we; u32 ext_op; u32 rf_we; u32 wr;
    u32 alu; u32 rd2; u32 rdata;
    u32 req; u32 wr_bus; u32 wstrb; u32 wdata;
    u32 vo; u32 rfwe_o; u32 ale_o; u32 chk_wd; u32 wd;
  } vec_t;

  vec_t vecs[14];
  int   passed = 0;
  int   total  = 0;
  int   stalls;

  task automatic chk(input string name, input u32 act, input u32 exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive_op(input logic v, input logic [1:0] sel, input logic [3:0] we,
                          input logic [2:0] op, input logic rfwe, input logic [4:0] wr,
                          input u32 alu, input u32 rd2);
    valid_in = v; wd_sel_in = sel; ram_we_in = we; ram_ext_op_in = op;
    rf_we_in = rfwe; wR_in = wr; alu_C_in = alu; rD2_in = rd2;
  endtask

  initial begin
    // positional: valid sel we op rfwe wr alu rd2 rdata | req wr wstrb wdata | vo rfwe ale chkwd wd
    vecs[0]  = '{1, 0, 0,   0, 1, 1,  32'h1234, 0, 0,                    0, 0, 0,    0,             1, 1, 0, 1, 32'h1234};
    vecs[1]  = '{1, 2, 0,   0, 1, 2,  32'h5555, 0, 0,                    0, 0, 0,    0,             1, 1, 0, 1, 32'h104};
    vecs[2]  = '{1, 3, 0,   0, 1, 3,  32'h5555, 0, 0,                    0, 0, 0,    0,             1, 1, 0, 1, 32'hFFFFF800};
    vecs[3]  = '{1, 1, 0,   1, 1, 4,  32'h1003, 0, 32'h80FFFFFF,         1, 0, 0,    0,             1, 1, 0, 1, 32'hFFFFFF80};
    vecs[4]  = '{1, 1, 0,   2, 1, 5,  32'h1001, 0, 32'h1234A578,         1, 0, 0,    0,             1, 1, 0, 1, 32'h000000A5};
    vecs[5]  = '{1, 1, 0,   3, 1, 6,  32'h1002, 0, 32'h9ABC1234,         1, 0, 0,    0,             1, 1, 0, 1, 32'hFFFF9ABC};
    vecs[6]  = '{1, 1, 0,   4, 1, 7,  32'h1000, 0, 32'h9ABC8001,         1, 0, 0,    0,             1, 1, 0, 1, 32'h00008001};
    vecs[7]  = '{1, 1, 0,   0, 1, 8,  32'h1004, 0, 32'hDEADBEEF,         1, 0, 0,    0,             1, 1, 0, 1, 32'hDEADBEEF};
    vecs[8]  = '{1, 0, 32'h3, 0, 0, 9,  32'h2002, 32'hAAAA5678, 0,       1, 1, 32'hC, 32'h56785678, 1, 0, 0, 1, 32'h2002};
    vecs[9]  = '{1, 0, 32'h1, 0, 0, 10, 32'h2001, 32'h12345699, 0,       1, 1, 32'h2, 32'h99999999, 1, 0, 0, 1, 32'h2001};
    vecs[10] = '{1, 0, 32'hF, 0, 0, 11, 32'h2004, 32'hCAFEF00D, 0,       1, 1, 32'hF, 32'hCAFEF00D, 1, 0, 0, 1, 32'h2004};
    vecs[11] = '{1, 1, 0,   0, 1, 12, 32'h3002, 0, 0,                    0, 0, 0,    0,             1, 0, 1, 0, 0};
    vecs[12] = '{1, 0, 32'h3, 0, 0, 13, 32'h2003, 32'h1, 0,              0, 1, 32'h8, 0,            1, 0, 1, 1, 32'h2003};
    vecs[13] = '{0, 1, 0,   0, 1, 14, 32'h1008, 0, 0,                    0, 0, 0,    0,             0, 0, 0, 1, 32'h2003};

    pc4_in = 32'h104; ext_in = 32'hFFFFF800;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    drive_op(0, 0, 0, 0, 0, 0, 0, 0);
    cpu_rst = 1'b1;
    #1;
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_wd_out",    wd_out, 0);
    chk("rst_stall",     32'(mem_stall), 0);
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge cpu_clk);
      drive_op(vecs[i].valid[0], vecs[i].wd_sel[1:0], vecs[i].ram_we[3:0], vecs[i].ext_op[2:0],
               vecs[i].rf_we[0], vecs[i].wr[4:0], vecs[i].alu, vecs[i].rd2);
      data_rdata = vecs[i].rdata; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #1;
      chk($sformatf("v%0d_req", i),   32'(data_req), vecs[i].req);
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), vecs[i].req);
      chk($sformatf("v%0d_wstrb", i), 32'(data_wstrb), vecs[i].wstrb);
      if (vecs[i].req[0]) begin
        chk($sformatf("v%0d_addr", i), data_addr, vecs[i].alu & 32'hFFFFFFFC);
        chk($sformatf("v%0d_wr", i),   32'(data_wr), vecs[i].wr_bus);
        if (vecs[i].wr_bus[0]) chk($sformatf("v%0d_wdata", i), data_wdata, vecs[i].wdata);
        data_addr_ok = 1'b1;
        @(negedge cpu_clk);
        data_addr_ok = 1'b0;
        #1;
        chk($sformatf("v%0d_wait_req", i),   32'(data_req), 0);
        chk($sformatf("v%0d_wait_stall", i), 32'(mem_stall), 1);
        data_data_ok = 1'b1;
        #1;
        chk($sformatf("v%0d_done_stall", i), 32'(mem_stall), 0);
      end
      @(posedge cpu_clk);
      #1;
      data_data_ok = 1'b0;
      chk($sformatf("v%0d_valid_out", i), 32'(valid_out), vecs[i].vo);
      chk($sformatf("v%0d_rf_we_out", i), 32'(rf_we_out), vecs[i].rfwe_o);
      chk($sformatf("v%0d_ale_out", i),   32'(ale_out),   vecs[i].ale_o);
      if (vecs[i].chk_wd[0]) chk($sformatf("v%0d_wd_out", i), wd_out, vecs[i].wd);
      if (vecs[i].vo[0])     chk($sformatf("v%0d_wR_out", i), 32'(wR_out), vecs[i].wr);
    end

    // Signed byte load: addr_ok immediate, one empty WAIT cycle, then data
    @(negedge cpu_clk);
    drive_op(1, 1, 0, 1, 1, 5'd20, 32'h1003, 0);
    data_rdata = 32'h80FFFFFF; data_addr_ok = 1'b1; stalls = 0;
    #1; if (mem_stall) stalls++;
    @(negedge cpu_clk); data_addr_ok = 1'b0;
    #1; if (mem_stall) stalls++;
    chk("seq2_bubble", 32'(valid_out), 0);
    @(negedge cpu_clk); data_data_ok = 1'b1;
    #1; if (mem_stall) stalls++;
    chk("seq2_stall_cycles", stalls, 2);
    @(posedge cpu_clk); #1; data_data_ok = 1'b0;
    chk("seq2_wd_out", wd_out, 32'hFFFFFF80);
    chk("seq2_valid_out", 32'(valid_out), 1);

    // Word load with addr_ok held off for three cycles
    @(negedge cpu_clk);
    drive_op(1, 1, 0, 0, 1, 5'd21, 32'h4000, 0);
    data_rdata = 32'h11223344;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("seq4_req_c%0d", c),  32'(data_req), 1);
      chk($sformatf("seq4_addr_c%0d", c), data_addr, 32'h4000);
      if (c == 3) data_addr_ok = 1'b1;
      @(posedge cpu_clk); #1;
      chk($sformatf("seq4_bubble_c%0d", c), 32'(valid_out), 0);
      @(negedge cpu_clk);
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    @(posedge cpu_clk); #1; data_data_ok = 1'b0;
    chk("seq4_wd_out", wd_out, 32'h11223344);
    chk("seq4_wR_out", 32'(wR_out), 21);

    // Reset mid-transaction, then a fresh load
    @(negedge cpu_clk);
    drive_op(1, 1, 0, 2, 1, 5'd22, 32'h5000, 0);
    data_addr_ok = 1'b1;
    @(negedge cpu_clk);
    data_addr_ok = 1'b0;
    #1; chk("seq6_in_wait", 32'(data_req), 0);
    cpu_rst = 1'b1; valid_in = 1'b0;
    #1;
    chk("seq6_rst_wd_out", wd_out, 0);
    chk("seq6_rst_wR_out", 32'(wR_out), 0);
    chk("seq6_rst_valid",  32'(valid_out | rf_we_out | ale_out), 0);
    chk("seq6_rst_stall",  32'(mem_stall), 0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    drive_op(1, 1, 0, 0, 1, 5'd23, 32'h6000, 0);
    data_rdata = 32'hA5A55A5A; data_addr_ok = 1'b1;
    #1; chk("seq6_fresh_req", 32'(data_req), 1);
    @(negedge cpu_clk); data_addr_ok = 1'b0; data_data_ok = 1'b1;
    @(posedge cpu_clk); #1; data_data_ok = 1'b0;
    chk("seq6_fresh_wd", wd_out, 32'hA5A55A5A);
    chk("seq6_fresh_valid", 32'(valid_out), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
